// File: rtl/mult_accum_sat_mc.sv
// mult_accum_sat_mc: one shared signed multiplier, CHANNELS saturating
// accumulators, 2-stage pipeline, per-channel clamped preload.
// Ports: clk, rst_n (async, low), sclr (sync clear)
//   request : in_valid, in_ch, a, b
//   limits  : lim_hi, lim_lo (quasi-static, signed)
//   preload : set_offset, offset_ch, offset
//   result  : out_valid, out_ch, s, overflow, underflow
module mult_accum_sat_mc #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 32,
  parameter int SHIFT     = 16,
  parameter int OUT_WIDTH = 32,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sclr,
  input  logic                        in_valid,
  input  logic [CH_BITS-1:0]          in_ch,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic signed [OUT_WIDTH-1:0] lim_hi,
  input  logic signed [OUT_WIDTH-1:0] lim_lo,
  input  logic                        set_offset,
  input  logic [CH_BITS-1:0]          offset_ch,
  input  logic signed [OUT_WIDTH-1:0] offset,
  output logic                        out_valid,
  output logic [CH_BITS-1:0]          out_ch,
  output logic signed [OUT_WIDTH-1:0] s,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int SW = OUT_WIDTH + 2;
  localparam logic [CH_BITS:0] NCH = (CH_BITS + 1)'(CHANNELS);

  if (A_WIDTH + B_WIDTH - SHIFT > OUT_WIDTH + 1) begin : g_bad_width
    $error("shifted product does not fit the accumulator");
  end
  if (CHANNELS < 1 || CH_BITS < 1 || (1 << CH_BITS) < CHANNELS) begin : g_bad_ch
    $error("CH_BITS too small for CHANNELS");
  end

  function automatic logic signed [OUT_WIDTH-1:0] sat(
    input logic signed [SW-1:0] x,
    input logic signed [SW-1:0] hi,
    input logic signed [SW-1:0] lo
  );
    logic signed [SW-1:0] r;
    r = (x > hi) ? hi : x;
    // lim_lo applied last so it wins when the limits are inverted
    r = (r < lo) ? lo : r;
    return OUT_WIDTH'(r);
  endfunction

  logic signed [OUT_WIDTH-1:0] acc [CHANNELS];

  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        prod_sh;
  logic signed [SW-1:0]        p_ext;
  logic                        in_ok;
  logic                        pre_ok;

  logic                        v1;
  logic [CH_BITS-1:0]          ch1;
  logic signed [SW-1:0]        p1;

  logic signed [OUT_WIDTH-1:0] acc_cur;
  logic signed [SW-1:0]        sum;
  logic signed [SW-1:0]        hi_x;
  logic signed [SW-1:0]        lo_x;
  logic signed [SW-1:0]        off_x;
  logic signed [OUT_WIDTH-1:0] acc_new;
  logic signed [OUT_WIDTH-1:0] pre_val;

  assign prod    = PW'(a) * PW'(b);
  assign prod_sh = prod >>> SHIFT;
  // the shifted product always fits SW bits, so the cast never loses value
  assign p_ext   = SW'(prod_sh);

  assign in_ok  = in_valid && ({1'b0, in_ch} < NCH);
  assign pre_ok = set_offset && ({1'b0, offset_ch} < NCH);

  assign hi_x    = SW'(lim_hi);
  assign lo_x    = SW'(lim_lo);
  assign off_x   = SW'(offset);
  assign acc_cur = acc[ch1];
  // two guard bits: the sum of two OUT_WIDTH values cannot wrap
  assign sum     = SW'(acc_cur) + p1;
  assign acc_new = sat(sum, hi_x, lo_x);
  assign pre_val = sat(off_x, hi_x, lo_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      ch1 <= '0;
      p1  <= '0;
    end else if (sclr) begin
      v1 <= 1'b0;
    end else begin
      v1 <= in_ok;
      if (in_ok) begin
        ch1 <= in_ch;
        p1  <= p_ext;
      end
    end
  end

  // a preload to the channel being accumulated overrides the writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (sclr) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (pre_ok && offset_ch == CH_BITS'(i)) begin
          acc[i] <= pre_val;
        end else if (v1 && ch1 == CH_BITS'(i)) begin
          acc[i] <= acc_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      s         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sclr) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      s         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (v1) begin
      out_valid <= 1'b1;
      out_ch    <= ch1;
      s         <= acc_new;
      overflow  <= sum > hi_x;
      underflow <= sum < lo_x;
    end else begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_accum_sat_mc.sv
// tb_mult_accum_sat_mc: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_mult_accum_sat_mc;

  localparam int NCH = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sclr;
  logic               in_valid;
  logic [1:0]         in_ch;
  logic signed [15:0] a;
  logic signed [31:0] b;
  logic signed [31:0] lim_hi;
  logic signed [31:0] lim_lo;
  logic               set_offset;
  logic [1:0]         offset_ch;
  logic signed [31:0] offset;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [31:0] s;
  logic               overflow;
  logic               underflow;

  int checks = 0;
  int errors = 0;

  localparam logic signed [31:0] MAXV = 32'sh7FFFFFFF;
  localparam logic signed [31:0] MINV = 32'sh80000000;

  mult_accum_sat_mc #(
    .A_WIDTH(16), .B_WIDTH(32), .SHIFT(16),
    .OUT_WIDTH(32), .CHANNELS(NCH), .CH_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .in_valid(in_valid), .in_ch(in_ch), .a(a), .b(b),
    .lim_hi(lim_hi), .lim_lo(lim_lo),
    .set_offset(set_offset), .offset_ch(offset_ch),
    .offset(offset),
    .out_valid(out_valid), .out_ch(out_ch), .s(s),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // reference model: plain integer arithmetic on per-channel totals
  longint             m_acc [4];
  bit                 q_v;
  logic [1:0]         q_ch;
  longint             q_p;
  logic               e_v, e_ov, e_un;
  logic [1:0]         e_ch;
  logic signed [31:0] e_s;

  function automatic longint sat(longint x, longint hi, longint lo);
    longint r;
    r = (x > hi) ? hi : x;
    r = (r < lo) ? lo : r;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    q_v = 0; q_ch = 0; q_p = 0;
    e_v = 0; e_ov = 0; e_un = 0; e_ch = 0; e_s = 0;
  endtask

  task automatic model_edge();
    longint hi, lo, sm, cl;
    int hit;
    hi = longint'(lim_hi);
    lo = longint'(lim_lo);
    if (!rst_n || sclr) begin
      model_reset();
      return;
    end
    hit = (set_offset && offset_ch < NCH) ? int'(offset_ch) : -1;
    if (q_v) begin
      sm = m_acc[q_ch] + q_p;
      cl = sat(sm, hi, lo);
      e_v = 1; e_ch = q_ch; e_s = 32'(cl);
      e_ov = sm > hi; e_un = sm < lo;
      if (int'(q_ch) != hit) m_acc[q_ch] = cl;
    end else begin
      e_v = 0; e_ov = 0; e_un = 0;
    end
    if (hit >= 0) m_acc[hit] = sat(longint'(offset), hi, lo);
    q_v  = in_valid && in_ch < NCH;
    q_ch = in_ch;
    q_p  = (longint'(a) * longint'(b)) >>> 16;
  endtask

  task automatic check_vec(string nm, logic [36:0] got, logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {v,ch,s,ov,un}=%h expected %h", nm, got, exp);
    end
  endtask

  task automatic expect_out(string nm, logic v, logic [1:0] ch,
                            logic signed [31:0] sv, logic ov, logic un);
    check_vec(nm, {out_valid, out_ch, s, overflow, underflow},
              {v, ch, sv, ov, un});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_vec("model", {out_valid, out_ch, s, overflow, underflow},
              {e_v, e_ch, e_s, e_ov, e_un});
    in_valid = 0; set_offset = 0; sclr = 0;
  endtask

  task automatic req(logic [1:0] ch, logic signed [15:0] av);
    in_valid = 1; in_ch = ch; a = av; b = 32'sh00010000;
  endtask

  task automatic clear();
    sclr = 1;
    tick();
    expect_out("sclr", 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic signed [31:0] hi, lo, pre;
    logic signed [15:0] av;
    logic signed [31:0] bv;
    logic signed [31:0] es;
    logic               eov, eun;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{MAXV, MINV, 32'sd0, 16'sd1, 32'sh10000, 32'sd1, 0, 0};
    vecs[1] = '{32'sd100, -32'sd100, 32'sd60, 16'sd60, 32'sh10000,
                32'sd100, 1, 0};
    vecs[2] = '{32'sd100, -32'sd50, -32'sd30, -16'sd30, 32'sh10000,
                -32'sd50, 0, 1};
    vecs[3] = '{-32'sd10, 32'sd10, 32'sd0, -16'sd10, 32'sh10000,
                32'sd10, 1, 1};
    vecs[4] = '{MAXV, MINV, 32'sd0, 16'sd3, 32'sh8000, 32'sd1, 0, 0};
    vecs[5] = '{MAXV, MINV, 32'sd0, -16'sd3, 32'sh8000, -32'sd2, 0, 0};
    vecs[6] = '{MAXV, MINV, 32'sh7FFF0000, 16'sh7FFF, 32'sh7FFFFFFF,
                MAXV, 1, 0};
    vecs[7] = '{MAXV, MINV, MINV, 16'sh8000, 32'sh7FFFFFFF, MINV, 0, 1};
    vecs[8] = '{MAXV, MINV, 32'sd0, 16'sh8000, 32'sh80000000,
                32'sh40000000, 0, 0};
    vecs[9] = '{32'sd1000, -32'sd1000, 32'sd5000, 16'sd0, 32'sh10000,
                32'sd1000, 0, 0};

    rst_n = 0; sclr = 0; in_valid = 0; in_ch = 0; a = 0; b = 0;
    lim_hi = MAXV; lim_lo = MINV;
    set_offset = 0; offset_ch = 0; offset = 0;
    model_reset();
    #2;
    expect_out("reset", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;

    // basic accumulation, back to back on one channel
    req(0, 1); tick();
    req(0, 1); tick(); expect_out("basic1", 1, 0, 1, 0, 0);
    req(0, 1); tick(); expect_out("basic2", 1, 0, 2, 0, 0);
    tick(); expect_out("basic3", 1, 0, 3, 0, 0);
    tick(); expect_out("hold", 0, 0, 3, 0, 0);

    // anti-windup at the upper limit
    clear(); lim_hi = 32'sd100;
    req(1, 60); tick();
    req(1, 60); tick(); expect_out("pos1", 1, 1, 60, 0, 0);
    req(1, -10); tick(); expect_out("pos2", 1, 1, 100, 1, 0);
    tick(); expect_out("pos3", 1, 1, 90, 0, 0);

    // lower limit
    clear(); lim_hi = MAXV; lim_lo = -32'sd50;
    req(2, -30); tick();
    req(2, -30); tick(); expect_out("neg1", 1, 2, -30, 0, 0);
    tick(); expect_out("neg2", 1, 2, -50, 0, 1);

    // channel interleave
    clear(); lim_lo = MINV;
    req(0, 5); tick();
    req(1, -7); tick(); expect_out("il0a", 1, 0, 5, 0, 0);
    req(0, 5); tick(); expect_out("il1a", 1, 1, -7, 0, 0);
    req(1, -7); tick(); expect_out("il0b", 1, 0, 10, 0, 0);
    tick(); expect_out("il1b", 1, 1, -14, 0, 0);

    // preload colliding with a stage-2 accumulate
    clear();
    req(2, 1); tick();
    set_offset = 1; offset_ch = 2; offset = 32'sh12340000;
    tick(); expect_out("coll_out", 1, 2, 1, 0, 0);
    req(2, 1); tick();
    tick(); expect_out("coll_acc", 1, 2, 32'sh12340001, 0, 0);

    // preload on the edge a request enters stage 1
    clear();
    req(0, 1); set_offset = 1; offset_ch = 0; offset = 32'sd1000;
    tick(); tick(); expect_out("pre_s1", 1, 0, 1001, 0, 0);

    // out-of-range channel and preload are dropped
    clear();
    req(3, 5); set_offset = 1; offset_ch = 3; offset = 32'sd77;
    tick(); tick(); expect_out("drop", 0, 0, 0, 0, 0);
    req(0, 1); tick(); tick(); expect_out("drop_acc", 1, 0, 1, 0, 0);

    // asynchronous reset mid-stream
    req(1, 9); tick();
    req(1, 9); tick();
    #2 rst_n = 0;
    #1 expect_out("async_rst", 0, 0, 0, 0, 0);
    model_reset();
    tick();
    rst_n = 1;
    tick(); expect_out("rst_kill", 0, 0, 0, 0, 0);
    req(1, 3); tick(); tick(); expect_out("rst_acc", 1, 1, 3, 0, 0);

    // synchronous clear kills the in-flight request
    req(2, 4); tick();
    sclr = 1; tick(); expect_out("sclr_now", 0, 0, 0, 0, 0);
    tick(); expect_out("sclr_kill", 0, 0, 0, 0, 0);
    req(2, 2); tick(); tick(); expect_out("sclr_acc", 1, 2, 2, 0, 0);

    // vector table: preload, one accumulate, check result
    for (int i = 0; i < 10; i++) begin
      clear();
      lim_hi = vecs[i].hi; lim_lo = vecs[i].lo;
      set_offset = 1; offset_ch = 1; offset = vecs[i].pre;
      tick();
      in_valid = 1; in_ch = 1; a = vecs[i].av; b = vecs[i].bv;
      tick(); tick();
      expect_out($sformatf("vec%0d", i), 1, 1, vecs[i].es,
                 vecs[i].eov, vecs[i].eun);
    end

    // randomized traffic, checked every cycle by the model
    lim_hi = MAXV; lim_lo = MINV;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          lim_hi = 32'($urandom);
          lim_lo = 32'($urandom);
        end else begin
          lim_hi = 32'($urandom >> $urandom_range(1, 12));
          lim_lo = -32'($urandom >> $urandom_range(1, 12));
        end
      end
      sclr       = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_ch      = 2'($urandom_range(0, 3));
      a          = 16'($urandom);
      b          = 32'($urandom >> $urandom_range(0, 20));
      if ($urandom_range(0, 1) == 0) b = -b;
      set_offset = ($urandom_range(0, 9) == 0);
      offset_ch  = 2'($urandom_range(0, 3));
      offset     = 32'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
